// File: rtl/pad_cfg_seq_if.sv
// Shadow-write bus for pad_cfg_seq.
// The master (core control registers / bootstrap) presents a write with
// wr_valid. The slave (pad_cfg_seq) accepts it when wr_ready is high.
//   wr_valid : write request
//   wr_ready : write accepted on wr_valid & wr_ready
//   wr_side  : 0=no 1=ea 2=so 3=we
//   wr_pad   : pad index within the side
//   wr_data  : config word
interface pad_cfg_seq_if #(
  parameter int unsigned CFGW = 18
);
  logic            wr_valid;
  logic            wr_ready;
  logic [1:0]      wr_side;
  logic [3:0]      wr_pad;
  logic [CFGW-1:0] wr_data;

  modport master (output wr_valid, wr_side, wr_pad, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_side, wr_pad, wr_data, output wr_ready);
endinterface

// File: rtl/pad_cfg_seq.sv
// Padring tech-config sequencer.
// Writes land in a shadow array. An apply then commits shadow to active one
// pad at a time. A per-pad hold brackets each pad's config change so that
// the core can gate that pad's output-enable while it switches.
// Ports:
//   clk, nreset   : clock, asynchronous active-low reset
//   wr            : shadow-write bus (slave side)
//   wr_err        : sticky, set when a write to a pad index >= NPINS is accepted
//   apply         : start a commit; sampled in IDLE only
//   busy, done    : commit in progress / one-cycle end-of-commit pulse
//   *_tech_cfg    : active config, pad p at [p*CFGW +: CFGW]
//   *_hold        : per-pad hold, at most one bit high across all sides
module pad_cfg_seq #(
  parameter int unsigned     NPINS      = 9,
  parameter int unsigned     CFGW       = 18,
  parameter logic [CFGW-1:0] CFG_RESET  = '0,
  parameter int unsigned     HOLD_CYC   = 2,
  parameter int unsigned     SETTLE_CYC = 4,
  parameter bit              SKIP_SAME  = 1'b1
) (
  input  logic                  clk,
  input  logic                  nreset,
  pad_cfg_seq_if.slave          wr,
  output logic                  wr_err,
  input  logic                  apply,
  output logic                  busy,
  output logic                  done,
  output logic [NPINS*CFGW-1:0] no_tech_cfg,
  output logic [NPINS*CFGW-1:0] ea_tech_cfg,
  output logic [NPINS*CFGW-1:0] so_tech_cfg,
  output logic [NPINS*CFGW-1:0] we_tech_cfg,
  output logic [NPINS-1:0]      no_hold,
  output logic [NPINS-1:0]      ea_hold,
  output logic [NPINS-1:0]      so_hold,
  output logic [NPINS-1:0]      we_hold
);

  typedef enum logic [2:0] {IDLE, SCAN, PRE, POST, FIN} state_t;

  state_t                  state;
  logic [CFGW-1:0]         shadow [4][NPINS];
  logic [CFGW-1:0]         active [4][NPINS];
  logic [3:0][NPINS-1:0]   hold;
  logic [1:0]              side;
  logic [3:0]              pad;
  logic [3:0]              cnt;
  logic                    wr_ready_q;
  logic                    skip;
  logic                    adv;
  logic                    last_pad;

  assign wr.wr_ready = wr_ready_q;
  assign last_pad    = (pad == 4'(NPINS - 1));

  // Pointer advances either from SCAN on an unchanged pad or at the end of
  // the settle window. Both paths share the single advance block below.
  always_comb begin
    skip = 1'b0;
    adv  = 1'b0;
    if (state == SCAN)
      skip = SKIP_SAME && (shadow[side][pad] == active[side][pad]);
    if (skip)
      adv = 1'b1;
    if (state == POST && cnt == 4'(SETTLE_CYC - 1))
      adv = 1'b1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      side       <= '0;
      pad        <= '0;
      cnt        <= '0;
      hold       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_err     <= 1'b0;
      wr_ready_q <= 1'b1;
      for (int unsigned s = 0; s < 4; s++) begin
        for (int unsigned p = 0; p < NPINS; p++) begin
          shadow[s][p] <= CFG_RESET;
          active[s][p] <= CFG_RESET;
        end
      end
    end else begin
      done <= 1'b0;

      // An accepted apply clears the sticky error; a bad write in the same
      // cycle re-sets it so that error is not lost.
      if (state == IDLE && apply)
        wr_err <= 1'b0;

      if (wr.wr_valid && wr_ready_q) begin
        if (wr.wr_pad < 4'(NPINS))
          shadow[wr.wr_side][wr.wr_pad] <= wr.wr_data;
        else
          wr_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (apply) begin
            state      <= SCAN;
            busy       <= 1'b1;
            wr_ready_q <= 1'b0;
            side       <= '0;
            pad        <= '0;
          end
        end
        SCAN: begin
          if (!skip) begin
            hold[side][pad] <= 1'b1;
            cnt             <= '0;
            state           <= PRE;
          end
        end
        PRE: begin
          if (cnt == 4'(HOLD_CYC - 1)) begin
            active[side][pad] <= shadow[side][pad];
            cnt               <= '0;
            state             <= POST;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        POST: begin
          if (adv)
            hold <= '0;
          else
            cnt <= cnt + 4'd1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if (adv) begin
        if (last_pad) begin
          pad  <= '0;
          side <= side + 2'd1;
          if (side == 2'd3) begin
            state      <= FIN;
            busy       <= 1'b0;
            done       <= 1'b1;
            wr_ready_q <= 1'b1;
          end else begin
            state <= SCAN;
          end
        end else begin
          pad   <= pad + 4'd1;
          state <= SCAN;
        end
      end
    end
  end

  for (genvar p = 0; p < NPINS; p++) begin : g_flat
    assign no_tech_cfg[p*CFGW +: CFGW] = active[0][p];
    assign ea_tech_cfg[p*CFGW +: CFGW] = active[1][p];
    assign so_tech_cfg[p*CFGW +: CFGW] = active[2][p];
    assign we_tech_cfg[p*CFGW +: CFGW] = active[3][p];
  end

  assign no_hold = hold[0];
  assign ea_hold = hold[1];
  assign so_hold = hold[2];
  assign we_hold = hold[3];

endmodule
